rx_block_lock: RTL and testbench



---
 rtl/rx_block_lock_pkg.sv | 12 +
 rtl/rx_block_lock.sv | 109 ++++++++++
 tb/tb_rx_block_lock.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_block_lock_pkg.sv
// Shared 64b/66b PCS definitions: sync header encodings and the block-lock state type.
package rx_block_lock_pkg;

  localparam logic [1:0] SYNC_HEADER_DATA = 2'b01;
  localparam logic [1:0] SYNC_HEADER_CTRL = 2'b10;

  typedef enum logic {
    TEST_SH   = 1'b0,
    SLIP_WAIT = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock controller: tests sync headers per window and
// pulses the RX gearbox slip until block boundaries align.
module rx_block_lock
  import rx_block_lock_pkg::*;
#(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVLD_MAX     = 16,
  parameter int SLIP_WAIT_CYCLES = 32,
  parameter int SLIP_COUNT_WIDTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [1:0]                  i_header,
  input  logic                        i_header_valid,
  output logic                        o_gearbox_slip,
  output logic                        o_block_lock,
  output logic [SLIP_COUNT_WIDTH-1:0] o_slip_count
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX - 1);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SLIP_WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  lock_state_t                 state, state_d;
  logic [CNT_W-1:0]            sh_cnt, sh_cnt_d;
  logic [INV_W-1:0]            sh_invld_cnt, sh_invld_cnt_d;
  logic [WAIT_W-1:0]           wait_cnt, wait_cnt_d;
  logic                        slip_q, slip_d;
  logic                        lock_q, lock_d;
  logic [SLIP_COUNT_WIDTH-1:0] slip_count_q, slip_count_d;
  logic                        sh_ok;
  logic                        do_slip;

  assign sh_ok = (i_header == SYNC_HEADER_DATA) || (i_header == SYNC_HEADER_CTRL);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= TEST_SH;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      slip_q       <= 1'b0;
      lock_q       <= 1'b0;
      slip_count_q <= '0;
    end else begin
      state        <= state_d;
      sh_cnt       <= sh_cnt_d;
      sh_invld_cnt <= sh_invld_cnt_d;
      wait_cnt     <= wait_cnt_d;
      slip_q       <= slip_d;
      lock_q       <= lock_d;
      slip_count_q <= slip_count_d;
    end
  end

  always_comb begin
    state_d        = state;
    sh_cnt_d       = sh_cnt;
    sh_invld_cnt_d = sh_invld_cnt;
    wait_cnt_d     = wait_cnt;
    slip_d         = 1'b0;
    lock_d         = lock_q;
    slip_count_d   = slip_count_q;
    do_slip        = 1'b0;

    case (state)
      TEST_SH: begin
        if (i_header_valid) begin
          // Unlock-and-slip outranks window end, so it is tested first.
          if (!sh_ok && (!lock_q || sh_invld_cnt == INV_LAST)) begin
            lock_d  = 1'b0;
            do_slip = 1'b1;
          end else if (sh_cnt == CNT_LAST) begin
            if (sh_invld_cnt == '0 && sh_ok) lock_d = 1'b1;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt + 1'b1;
            if (!sh_ok) sh_invld_cnt_d = sh_invld_cnt + 1'b1;
          end
        end
      end
      SLIP_WAIT: begin
        wait_cnt_d = wait_cnt - 1'b1;
        if (wait_cnt == WAIT_ONE) state_d = TEST_SH;
      end
      default: state_d = TEST_SH;
    endcase

    if (do_slip) begin
      sh_cnt_d       = '0;
      sh_invld_cnt_d = '0;
      slip_d         = 1'b1;
      wait_cnt_d     = WAIT_INIT;
      state_d        = SLIP_WAIT;
      if (slip_count_q != '1) slip_count_d = slip_count_q + 1'b1;
    end
  end

  assign o_gearbox_slip = slip_q;
  assign o_block_lock   = lock_q;
  assign o_slip_count   = slip_count_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: directed scenarios plus random traffic
// against a behavioural lock model; a 4-bit-counter instance covers saturation.
module tb_rx_block_lock;

  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  hdr;
  logic        hdr_valid;
  logic        slip, lock, slip4, lock4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_slip, m_lock;
  int m_cnt, m_inv, m_blind, m_slips;
  bit pat[64];

  always #5 clk = ~clk;

  rx_block_lock dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_header(hdr), .i_header_valid(hdr_valid),
    .o_gearbox_slip(slip), .o_block_lock(lock), .o_slip_count(cnt16)
  );

  rx_block_lock #(.SLIP_COUNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_header(hdr), .i_header_valid(hdr_valid),
    .o_gearbox_slip(slip4), .o_block_lock(lock4), .o_slip_count(cnt4)
  );

  wire [23:0] dut_vec = {slip, lock, cnt16, slip4, lock4, cnt4};

  function automatic logic [23:0] exp_vec();
    logic [15:0] c16;
    logic [3:0]  c4;
    c16 = (m_slips > 65535) ? 16'hFFFF : 16'(m_slips);
    c4  = (m_slips > 15) ? 4'hF : 4'(m_slips);
    return {m_slip, m_lock, c16, m_slip, m_lock, c4};
  endfunction

  // Model: after a slip, the next SLIP_WAIT edges are blind; otherwise a window
  // of 64 tested headers locks if clean, and too many bad headers force a slip.
  task automatic model_edge(input logic rn, input logic v, input logic [1:0] h);
    bit ok;
    if (!rn) begin
      m_slip = 0; m_lock = 0; m_cnt = 0; m_inv = 0; m_blind = 0; m_slips = 0;
      return;
    end
    m_slip = 0;
    if (m_blind > 0) begin
      m_blind--;
      return;
    end
    if (!v) return;
    ok = (h == 2'b01) || (h == 2'b10);
    m_cnt++;
    if (!ok) m_inv++;
    if (!ok && (!m_lock || m_inv == SH_INVLD_MAX)) begin
      m_lock = 0; m_cnt = 0; m_inv = 0;
      m_blind = SLIP_WAIT; m_slip = 1; m_slips++;
    end else if (m_cnt == SH_CNT_MAX) begin
      if (m_inv == 0) m_lock = 1;
      m_cnt = 0; m_inv = 0;
    end
  endtask

  task automatic step(input logic v, input logic [1:0] h);
    hdr_valid = v;
    hdr = h;
    @(posedge clk);
    model_edge(rst_n, v, h);
    #1;
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  // Marks n_bad distinct positions in pat[0..span-1].
  task automatic make_pattern(input int n_bad, input int span);
    int placed, p;
    foreach (pat[i]) pat[i] = 0;
    placed = 0;
    while (placed < n_bad) begin
      p = $urandom_range(0, span - 1);
      if (!pat[p]) begin pat[p] = 1; placed++; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    rst_n = 1'b1;
  endtask

  task automatic acquire_lock();
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      step(1'b1, good_hdr());
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL acquire: dut=%h model=%h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    hdr = 2'b00; hdr_valid = 1'b0;
    do_reset();
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL reset_state: dut=%h required=0", dut_vec);
    end
  endtask

  task automatic test_lock_acquire();
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      step(1'b0, 2'b11);
      checks++;
      if (lock !== 1'b0 || slip !== 1'b0) begin
        errors++; $display("FAIL acquire_early hdr %0d: lock=%b slip=%b required 0/0", i, lock, slip);
      end
      step(1'b1, 2'b01);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL acquire hdr %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (lock !== 1'b1 || cnt16 !== 16'd0) begin
      errors++; $display("FAIL acquire_final: lock=%b count=%0d required 1/0", lock, cnt16);
    end
  endtask

  task automatic test_slip_unlocked();
    do_reset();
    step(1'b1, 2'b11);
    checks++;
    if (slip !== 1'b1 || cnt16 !== 16'd1 || lock !== 1'b0) begin
      errors++; $display("FAIL slip_pulse: slip=%b count=%0d lock=%b required 1/1/0", slip, cnt16, lock);
    end
    for (int i = 0; i < SLIP_WAIT; i++) begin
      step(1'($urandom_range(0, 1)), bad_hdr());
      checks++;
      if (slip !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL slip_wait cyc %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    step(1'b1, 2'b11);
    checks++;
    if (slip !== 1'b1 || cnt16 !== 16'd2) begin
      errors++; $display("FAIL slip_retest: slip=%b count=%0d required 1/2", slip, cnt16);
    end
  endtask

  task automatic test_lock_hold();
    int p;
    do_reset();
    acquire_lock();
    make_pattern(15, SH_CNT_MAX);
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      step(1'b1, pat[i] ? bad_hdr() : good_hdr());
      checks++;
      if (slip !== 1'b0 || lock !== 1'b1 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL hold15 hdr %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    p = $urandom_range(15, 62);
    make_pattern(15, p);
    for (int i = 0; i < p; i++) begin
      step(1'b1, pat[i] ? bad_hdr() : good_hdr());
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL drop16 hdr %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    step(1'b1, bad_hdr());
    checks++;
    if (slip !== 1'b1 || lock !== 1'b0 || cnt16 !== 16'd1) begin
      errors++; $display("FAIL drop16_final: slip=%b lock=%b count=%0d required 1/0/1", slip, lock, cnt16);
    end
  endtask

  task automatic test_window_end_unlock();
    do_reset();
    acquire_lock();
    make_pattern(15, SH_CNT_MAX - 1);
    for (int i = 0; i < SH_CNT_MAX - 1; i++) begin
      step(1'b1, pat[i] ? bad_hdr() : good_hdr());
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL wend hdr %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    step(1'b1, bad_hdr());
    checks++;
    if (slip !== 1'b1 || lock !== 1'b0) begin
      errors++; $display("FAIL wend_priority: slip=%b lock=%b required 1/0", slip, lock);
    end
    for (int i = 0; i < SLIP_WAIT + SH_CNT_MAX - 1; i++) begin
      step(1'b1, good_hdr());
      checks++;
      if (lock !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL wend_norelock cyc %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20 * (1 + SLIP_WAIT); i++) begin
      step(1'b1, 2'b11);
      if (slip === 1'b1) pulses++;
      checks++;
      if (slip !== (i % (1 + SLIP_WAIT) == 0) || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL saturate cyc %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (cnt4 !== 4'hF || cnt16 !== 16'd20 || pulses != 20) begin
      errors++; $display("FAIL saturate_final: cnt4=%0d cnt16=%0d pulses=%0d required 15/20/20", cnt4, cnt16, pulses);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    acquire_lock();
    for (int i = 0; i < SH_INVLD_MAX; i++) step(1'b1, bad_hdr());
    for (int i = 0; i < 10; i++) step(1'b0, 2'b01);
    rst_n = 1'b0;
    step(1'b1, 2'b01);
    rst_n = 1'b1;
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL midwait_reset: dut=%h required=0", dut_vec);
    end
    acquire_lock();
    checks++;
    if (lock !== 1'b1) begin
      errors++; $display("FAIL midwait_relock: lock=%b required 1", lock);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 39) == 0) ? bad_hdr() : good_hdr());
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_lock_acquire();
    test_slip_unlocked();
    test_lock_hold();
    test_window_end_unlock();
    test_saturate();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
